// File: rtl/cmp8_pkg.sv
// Shared types and constants for the cmp8 magnitude comparator.
package cmp8_pkg;

   localparam int unsigned CMP_WIDTH = 8;

   // Comparator result flags, one-hot outside reset.
   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_flags_t;

   // All flags clear: only legal while (or just after) reset.
   localparam cmp_flags_t FLAGS_RST = 3'b000;

endpackage : cmp8_pkg

// File: rtl/cmp_bit_slice.sv
// Single-bit cell of an MSB-first magnitude compare cascade.
module cmp_bit_slice (
   input  logic gt_in,
   input  logic eq_in,
   input  logic a_bit,
   input  logic b_bit,
   output logic gt_out,
   output logic eq_out
);

   // A higher bit already decided "greater", or all higher bits equal and this bit has a=1, b=0.
   always_comb begin
      gt_out = gt_in | (eq_in & a_bit & ~b_bit);
      eq_out = eq_in & ~(a_bit ^ b_bit);
   end

endmodule : cmp_bit_slice

// File: rtl/cmp8.sv
// Unsigned magnitude comparator with registered, one-hot gt/eq/lt flags.
module cmp8
   import cmp8_pkg::*;
#(
   parameter int unsigned WIDTH = CMP_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             i,
   output logic             j,
   output logic             k
);

   // Cascade links: index WIDTH is the seed above the MSB, index 0 is the final result.
   logic [WIDTH:0] gt_chain;
   logic [WIDTH:0] eq_chain;
   cmp_flags_t     flags_c;
   cmp_flags_t     flags_q;

   assign gt_chain[WIDTH] = 1'b0;
   assign eq_chain[WIDTH] = 1'b1;

   for (genvar n = WIDTH - 1; n >= 0; n--) begin : g_slice
      cmp_bit_slice u_slice (
         .gt_in  (gt_chain[n+1]),
         .eq_in  (eq_chain[n+1]),
         .a_bit  (a[n]),
         .b_bit  (b[n]),
         .gt_out (gt_chain[n]),
         .eq_out (eq_chain[n])
      );
   end

   // Derive less-than from the cascade result.
   always_comb begin
      flags_c    = FLAGS_RST;
      flags_c.gt = gt_chain[0];
      flags_c.eq = eq_chain[0];
      flags_c.lt = ~gt_chain[0] & ~eq_chain[0];
   end

   // Output register; reset wins over the compare result.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= FLAGS_RST;
      end else begin
         flags_q <= flags_c;
      end
   end

   assign i = flags_q.gt;
   assign j = flags_q.eq;
   assign k = flags_q.lt;

endmodule : cmp8

// File: tb/tb_cmp8.sv
// Directed and exhaustive checks for the cmp8 registered comparator.
module tb_cmp8;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic       i;
   logic       j;
   logic       k;

   int total;
   int bad;

   cmp8 #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .i   (i),
      .j   (j),
      .k   (k)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive operands, then sample the flags 1 time unit after the next rising edge.
   task automatic apply(input logic [7:0] av, input logic [7:0] bv);
      a = av;
      b = bv;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         apply(8'd22, 8'd12);
         total++;
         if ({i, j, k} !== 3'b000) begin
            bad++;
            $display("FAIL reset_hold cycle %0d: got %b want 000", c, {i, j, k});
         end
      end
      rst = 1'b0;
      apply(8'd22, 8'd12);
      total++;
      if ({i, j, k} !== 3'b100) begin
         bad++;
         $display("FAIL reset_release: got %b want 100", {i, j, k});
      end
   endtask

   task automatic test_basic();
      logic [7:0] av [4];
      logic [7:0] bv [4];
      logic [2:0] ev [4];
      av = '{8'd0,   8'd22,  8'd12,  8'd22};
      bv = '{8'd0,   8'd12,  8'd22,  8'd22};
      ev = '{3'b010, 3'b100, 3'b001, 3'b010};
      for (int n = 0; n < 4; n++) begin
         apply(av[n], bv[n]);
         total++;
         if ({i, j, k} !== ev[n]) begin
            bad++;
            $display("FAIL basic a=%0d b=%0d: got %b want %b", av[n], bv[n], {i, j, k}, ev[n]);
         end
      end
   endtask

   task automatic test_unsigned_edges();
      logic [7:0] av [4];
      logic [7:0] bv [4];
      logic [2:0] ev [4];
      av = '{8'd255, 8'd128, 8'd0,   8'd254};
      bv = '{8'd0,   8'd127, 8'd255, 8'd255};
      ev = '{3'b100, 3'b100, 3'b001, 3'b001};
      for (int n = 0; n < 4; n++) begin
         apply(av[n], bv[n]);
         total++;
         if ({i, j, k} !== ev[n]) begin
            bad++;
            $display("FAIL edge a=%0d b=%0d: got %b want %b", av[n], bv[n], {i, j, k}, ev[n]);
         end
      end
   endtask

   task automatic test_mid_reset();
      apply(8'd200, 8'd3);
      total++;
      if ({i, j, k} !== 3'b100) begin
         bad++;
         $display("FAIL mid_reset_pre: got %b want 100", {i, j, k});
      end
      rst = 1'b1;
      apply(8'd5, 8'd9);
      total++;
      if ({i, j, k} !== 3'b000) begin
         bad++;
         $display("FAIL mid_reset_hold: got %b want 000", {i, j, k});
      end
      rst = 1'b0;
      apply(8'd5, 8'd9);
      total++;
      if ({i, j, k} !== 3'b001) begin
         bad++;
         $display("FAIL mid_reset_release: got %b want 001", {i, j, k});
      end
   endtask

   task automatic test_exhaustive();
      logic [2:0] exp_f;
      int         errs;
      errs = 0;
      for (int x = 0; x < 256; x++) begin
         for (int y = 0; y < 256; y++) begin
            exp_f = (x > y) ? 3'b100 : ((x == y) ? 3'b010 : 3'b001);
            apply(8'(x), 8'(y));
            total++;
            if ({i, j, k} !== exp_f) begin
               bad++;
               if (errs < 10) begin
                  $display("FAIL exhaustive a=%0d b=%0d: got %b want %b", x, y, {i, j, k}, exp_f);
               end
               errs++;
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ra;
      logic [7:0] rb;
      logic [2:0] exp_f;
      for (int n = 0; n < 2000; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = (n % 4 == 0) ? ra : 8'($urandom_range(0, 255));
         exp_f = (ra > rb) ? 3'b100 : ((ra == rb) ? 3'b010 : 3'b001);
         apply(ra, rb);
         total++;
         if ({i, j, k} !== exp_f || $countones({i, j, k}) != 1) begin
            bad++;
            $display("FAIL b2b a=%0d b=%0d: got %b want %b", ra, rb, {i, j, k}, exp_f);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      a     = 8'd22;
      b     = 8'd12;
      test_reset();
      test_basic();
      test_unsigned_edges();
      test_mid_reset();
      test_exhaustive();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cmp8
